serial_addsub: RTL and testbench
================================

# serial_addsub

Bit-serial one-digit add/subtract engine for the calculator datapath. Accepts two decimal digits and an operator, then drives the existing single-bit `fulladder` one bit per clock. It accumulates the sum bits and the carry, and returns an unsigned magnitude plus a sign flag. It sits directly upstream of the `fulladder` cell, which it instantiates, and downstream of operand entry.

## Interface
- `DIGIT_W`, default 4: operand width in bits.
- `MAX_DIGIT`, default 9: largest legal operand value.
- `clk`  in  1  the single clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `a`  in  DIGIT_W  first operand (0..9).
- `b`  in  DIGIT_W  second operand (0..9).
- `op`  in  1  operator: 0 = add, 1 = subtract (a - b).
- `busy`  out  1  high from the edge that accepts `start` until the edge that raises `done`.
- `done`  out  1  one-cycle pulse; `res`, `neg` and `err` are valid from this cycle onward.
- `res`  out  DIGIT_W+1  result magnitude (0..18).
- `neg`  out  1  result is negative (subtract only).
- `err`  out  1  an operand exceeded MAX_DIGIT.

## Operation
- **Reset:** `rst` high at any edge forces IDLE and clears `busy`, `done`, `res`, `neg`, `err`, the carry flop and the bit counter. This applies mid-operation too: the job is aborted and `done` is not emitted.
- **IDLE, start=1, an operand > MAX_DIGIT:**
  - go to DONE;
  - `err` = 1, `res` = 0, `neg` = 0.
- **IDLE, start=1, operands legal:**
  - latch `a` into shift register `sa`, latch `b ^ {DIGIT_W{op}}` into `sb`, and latch `op`;
  - load carry flop with `op` (two's-complement +1 for subtract);
  - clear `err`;
  - go to SUM with counter = 0.
- **SUM (DIGIT_W cycles):**
  - `fulladder` inputs are `sa[0]`, `sb[0]` and the carry flop;
  - each edge shifts `sum` into `r` from the MSB side, shifts `sa`/`sb` right, stores `carry` in the carry flop, and increments the counter;
  - after DIGIT_W edges go to FIX.
- **FIX (one edge):**
  - add: `res` = {carry, r}, `neg` = 0, go to DONE.
  - subtract with carry = 1 (a >= b): `res` = {0, r}, `neg` = 0, go to DONE.
  - subtract with carry = 0 (a < b): load `sa` = ~r, `sb` = 0, carry = 1, counter = 0, go to NEGATE.
- **NEGATE (DIGIT_W cycles):**
  - same serial pass as SUM, which forms the two's complement of `r`;
  - the last edge writes `res` = {0, magnitude}, sets `neg` = 1 and goes to DONE.
- **DONE (one cycle):**
  - `done` = 1; `busy` drops on the same edge that raises `done`;
  - next edge returns to IDLE.
- **Holding and ignored requests:**
  - `res`, `neg` and `err` hold until the next accepted `start` or `rst`;
  - `start` while busy or in DONE is ignored (no queuing).

## Timing
- Edge 0 is the edge that samples `start`.
- Latency:
  - invalid operand: `done` visible after edge 1;
  - add, or subtract with a >= b: `done` visible after edge 5;
  - subtract with a < b: `done` visible after edge 9.
- Throughput: a new `start` is accepted at the earliest one cycle after `done`.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package `calc_pkg` holds:
  - DIGIT_W and MAX_DIGIT constants;
  - OP_ADD = 0 and OP_SUB = 1;
  - the state enum IDLE, SUM, FIX, NEGATE, DONE.
- The existing `fulladder` is instantiated exactly once as the sole sub-module. No other arithmetic operators are used on the data path.
- The counter is 2 bits wide (log2 of DIGIT_W).

## Test plan
- a=3, b=4, op=0 -> `done` after edge 5, `res`=7, `neg`=0, `err`=0, `busy` high for edges 0..4.
- a=9, b=9, op=0 -> `res`=5'b10010 (18), `neg`=0.
- a=7, b=2, op=1 -> `res`=5, `neg`=0, `done` after edge 5.
- a=5, b=5, op=1 -> `res`=0, `neg`=0.
- a=2, b=7, op=1 -> `res`=5, `neg`=1, `done` after edge 9.
- a=10, b=1, op=0 -> `err`=1, `res`=0, `done` after edge 1.
- `start` pulsed again at edge 2 of a running job -> ignored, first result unchanged.
- `rst` asserted at edge 3 of a subtract -> all outputs 0, no `done`; a fresh 1+1 then yields `res`=2.

Source files
------------

// File: rtl/serial_addsub_pkg.sv
// Shared constants and FSM state encoding for the bit-serial digit add/subtract engine.
package calc_pkg;

    localparam int DIGIT_W   = 4;
    localparam int MAX_DIGIT = 9;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        SUM,
        FIX,
        NEGATE,
        DONE
    } state_e;

endpackage

// File: rtl/serial_addsub_if.sv
// Request/result bundle between operand entry (master) and the serial add/sub engine (slave).
interface serial_addsub_if #(
    parameter int DIGIT_W = calc_pkg::DIGIT_W
);
    logic               start;
    logic [DIGIT_W-1:0] a;
    logic [DIGIT_W-1:0] b;
    logic               op;
    logic               busy;
    logic               done;
    logic [DIGIT_W:0]   res;
    logic               neg;
    logic               err;

    modport master (
        output start, a, b, op,
        input  busy, done, res, neg, err
    );

    modport slave (
        input  start, a, b, op,
        output busy, done, res, neg, err
    );
endinterface

// File: rtl/serial_addsub_fulladder.sv
// Single-bit full adder cell used by the serial add/subtract datapath.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_addsub.sv
// Bit-serial one-digit add/subtract engine: one fulladder pass per bit, optional
// second pass to turn a negative two's-complement difference into a magnitude.
//
// state  | meaning
// IDLE   | waiting for start; results held
// SUM    | serial a + b (or a + ~b + 1), one bit per edge
// FIX    | inspect final carry, publish result or schedule negation
// NEGATE | serial ~r + 1 to form magnitude of a negative difference
// DONE   | done pulse cycle, then back to IDLE
module serial_addsub #(
    parameter int DIGIT_W   = calc_pkg::DIGIT_W,
    parameter int MAX_DIGIT = calc_pkg::MAX_DIGIT
) (
    input logic           clk,
    input logic           rst,
    serial_addsub_if.slave bus
);
    import calc_pkg::*;

    localparam int                 CNT_W    = (DIGIT_W > 2) ? $clog2(DIGIT_W) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DIGIT_W - 1);
    localparam logic [DIGIT_W-1:0] MAX_V    = DIGIT_W'(MAX_DIGIT);

    state_e             state_q, state_d;
    logic [DIGIT_W-1:0] sa_q, sa_d;
    logic [DIGIT_W-1:0] sb_q, sb_d;
    logic [DIGIT_W-1:0] r_q, r_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               op_q, op_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [DIGIT_W:0]   res_q, res_d;
    logic               neg_q, neg_d;
    logic               err_q, err_d;

    logic               fa_sum;
    logic               fa_cout;
    logic [DIGIT_W-1:0] r_shift;

    fulladder u_fa (
        .a    (sa_q[0]),
        .b    (sb_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    assign r_shift = {fa_sum, r_q[DIGIT_W-1:1]};

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        r_d     = r_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        res_d   = res_q;
        neg_d   = neg_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    busy_d = 1'b1;
                    if ((bus.a > MAX_V) || (bus.b > MAX_V)) begin
                        err_d   = 1'b1;
                        res_d   = '0;
                        neg_d   = 1'b0;
                        state_d = DONE;
                    end else begin
                        sa_d    = bus.a;
                        sb_d    = bus.b ^ {DIGIT_W{bus.op}};
                        op_d    = bus.op;
                        carry_d = bus.op;
                        err_d   = 1'b0;
                        cnt_d   = '0;
                        state_d = SUM;
                    end
                end
            end

            SUM, NEGATE: begin
                r_d     = r_shift;
                sa_d    = sa_q >> 1;
                sb_d    = sb_q >> 1;
                carry_d = fa_cout;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    if (state_q == SUM) begin
                        state_d = FIX;
                    end else begin
                        res_d   = {1'b0, r_shift};
                        neg_d   = 1'b1;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = DONE;
                    end
                end
            end

            FIX: begin
                if (op_q == OP_ADD || carry_q) begin
                    // add keeps the carry as the result MSB; a subtract carry only means a >= b
                    res_d   = (op_q == OP_ADD) ? {carry_q, r_q} : {1'b0, r_q};
                    neg_d   = 1'b0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end else begin
                    sa_d    = ~r_q;
                    sb_d    = '0;
                    carry_d = 1'b1;
                    cnt_d   = '0;
                    state_d = NEGATE;
                end
            end

            DONE: begin
                // operand errors arrive here straight from IDLE and raise done one edge later
                if (done_q) begin
                    state_d = IDLE;
                end else begin
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            r_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            op_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            res_q   <= '0;
            neg_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            r_q     <= r_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            res_q   <= res_d;
            neg_q   <= neg_d;
            err_q   <= err_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.res  = res_q;
    assign bus.neg  = neg_q;
    assign bus.err  = err_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub with a queue of expected results checked at each done.
module tb_serial_addsub;
    import calc_pkg::*;

    typedef struct {
        int res;
        bit neg;
        bit err;
        int lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    serial_addsub_if #(.DIGIT_W(DIGIT_W)) bus ();

    serial_addsub #(
        .DIGIT_W   (DIGIT_W),
        .MAX_DIGIT (MAX_DIGIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int a, input int b, input bit op);
        exp_t e;
        e.err = (a > MAX_DIGIT) || (b > MAX_DIGIT);
        e.neg = 1'b0;
        if (e.err) begin
            e.res = 0;
            e.lat = 1;
        end else if (!op) begin
            e.res = a + b;
            e.lat = 5;
        end else if (a >= b) begin
            e.res = a - b;
            e.lat = 5;
        end else begin
            e.res = b - a;
            e.neg = 1'b1;
            e.lat = 9;
        end
        return e;
    endfunction

    // restart_at > 0 pulses a second start so that it is sampled at that edge
    task automatic run_job(input int a, input int b, input bit op, input int restart_at);
        exp_t e;
        int   n;
        int   extra;
        bit   seen;
        sb_q.push_back(model(a, b, op));
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = DIGIT_W'(a);
        bus.b     = DIGIT_W'(b);
        bus.op    = op;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("busy_after_accept", bus.busy, 1);
        seen = 1'b0;
        n    = 0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            if (k == restart_at) begin
                bus.start = 1'b1;
                bus.a     = 1;
                bus.b     = 1;
                bus.op    = OP_ADD;
            end
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                n    = k;
            end else begin
                check("busy_while_running", bus.busy, 1);
            end
        end
        check("done_seen", seen, 1);
        if (seen) begin
            e = sb_q.pop_front();
            check("latency", n, e.lat);
            check("res", bus.res, e.res);
            check("neg", bus.neg, e.neg);
            check("err", bus.err, e.err);
            check("busy_at_done", bus.busy, 0);
            extra = 0;
            for (int k = 0; k < 6; k++) begin
                @(posedge clk);
                #1;
                if (bus.done === 1'b1) extra++;
            end
            check("no_extra_done", extra, 0);
            check("res_held", bus.res, e.res);
            check("neg_held", bus.neg, e.neg);
        end
    endtask

    initial begin
        int dones;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.op    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_res", bus.res, 0);
        check("reset_neg", bus.neg, 0);
        check("reset_err", bus.err, 0);
        @(negedge clk);
        rst = 1'b0;

        run_job(3, 4, OP_ADD, 0);
        run_job(9, 9, OP_ADD, 0);
        run_job(7, 2, OP_SUB, 0);
        run_job(5, 5, OP_SUB, 0);
        run_job(10, 1, OP_ADD, 0);
        run_job(6, 8, OP_ADD, 2);
        run_job(0, 9, OP_SUB, 0);
        run_job(4, 11, OP_SUB, 0);
        run_job(2, 7, OP_SUB, 0);

        // abort a subtract with reset sampled at edge 3
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 2;
        bus.b     = 7;
        bus.op    = OP_SUB;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_res", bus.res, 0);
        check("abort_neg", bus.neg, 0);
        check("abort_err", bus.err, 0);
        @(negedge clk);
        rst   = 1'b0;
        dones = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) dones++;
        end
        check("no_done_after_abort", dones, 0);

        run_job(1, 1, OP_ADD, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
